// File: rtl/axis_conv_accumulator_pkg.sv
// axis_conv_accumulator_pkg: shared widths, types and sideband flag positions for the conv accumulator.
package conv_pkg;
    localparam int DATA_WIDTH        = 16;
    localparam int CONV_UNITS        = 8;
    localparam int ACC_WIDTH         = 40;
    localparam int TUSER_WIDTH       = 4;
    localparam int KERNEL_W_MAX      = 3;
    localparam int CIN_COUNTER_WIDTH = 5;
    localparam int KW_WIDTH          = $clog2(KERNEL_W_MAX + 1);
    localparam int TAP_WIDTH         = KW_WIDTH + CIN_COUNTER_WIDTH + 1;
    localparam int IS_1x1            = 0;
    localparam int IS_MAX            = 1;
    localparam int IS_RELU           = 2;
    localparam int IS_COLS_1_K2      = 3;
    typedef logic signed [DATA_WIDTH-1:0] pix_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic [TUSER_WIDTH-1:0]       tuser_t;
    typedef logic [KW_WIDTH-1:0]          kw_t;
    typedef logic [CIN_COUNTER_WIDTH-1:0] cin_t;
    typedef logic [TAP_WIDTH-1:0]         tap_t;
    function automatic tap_t tap_total(kw_t kw1, cin_t cin1);
        return (tap_t'(kw1) + 1'b1) * (tap_t'(cin1) + 1'b1);
    endfunction
endpackage

// File: rtl/axis_conv_accumulator_if.sv
// axis_conv_accumulator_if: pixel, weight and result streams of the conv accumulator.
interface axis_conv_accumulator_if;
    import conv_pkg::*;
    pix_t   S_AXIS_tdata [CONV_UNITS];
    logic   S_AXIS_tvalid;
    logic   S_AXIS_tready;
    logic   S_AXIS_tlast;
    tuser_t S_AXIS_tuser;
    pix_t   W_AXIS_tdata;
    logic   W_AXIS_tvalid;
    logic   W_AXIS_tready;
    acc_t   M_AXIS_tdata [CONV_UNITS];
    logic   M_AXIS_tvalid;
    logic   M_AXIS_tready;
    tuser_t M_AXIS_tuser;
    modport master (
        output S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tuser, W_AXIS_tdata, W_AXIS_tvalid, M_AXIS_tready,
        input  S_AXIS_tready, W_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tuser
    );
    modport slave (
        input  S_AXIS_tdata, S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tuser, W_AXIS_tdata, W_AXIS_tvalid, M_AXIS_tready,
        output S_AXIS_tready, W_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tuser
    );
endinterface

// File: rtl/axis_conv_accumulator_mac.sv
// conv_mac_unit: one signed multiply-accumulate lane; o_sum is the value the accumulator takes on i_en.
module conv_mac_unit
    import conv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_first,
    input  pix_t i_pix,
    input  pix_t i_w,
    output acc_t o_sum
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    acc_t r_acc;
    assign w_prod = i_pix * i_w;
    assign o_sum  = (i_first ? '0 : r_acc) + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (i_en)
            r_acc <= o_sum;
    end
endmodule

// File: rtl/axis_conv_accumulator.sv
// axis_conv_accumulator: lockstep pixel/weight handshake, per-unit MAC, tap counting and result register.
module axis_conv_accumulator
    import conv_pkg::*;
(
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    input  kw_t                           kernel_w_1,
    input  cin_t                          cin_1,
    axis_conv_accumulator_if.slave        axis,
    output logic                          tap_error
);
    logic   w_can_acc, w_fire, w_last_fire, w_last_tap;
    acc_t   w_sum [CONV_UNITS];
    acc_t   r_mdata [CONV_UNITS];
    logic   r_mvalid, r_first, r_err;
    tuser_t r_muser;
    tap_t   r_cnt;
    kw_t    r_kw;
    cin_t   r_cin;

    // A result may be replaced in the same cycle it is taken, so no bubble between groups.
    assign w_can_acc          = !r_mvalid | axis.M_AXIS_tready;
    assign axis.S_AXIS_tready = !areset & axis.W_AXIS_tvalid & w_can_acc;
    assign axis.W_AXIS_tready = !areset & axis.S_AXIS_tvalid & w_can_acc;
    assign w_fire             = axis.S_AXIS_tvalid & axis.S_AXIS_tready;
    assign w_last_fire        = w_fire & axis.S_AXIS_tlast;
    assign w_last_tap         = (r_cnt + 1'b1) == tap_total(r_kw, r_cin);
    assign axis.M_AXIS_tdata  = r_mdata;
    assign axis.M_AXIS_tvalid = r_mvalid;
    assign axis.M_AXIS_tuser  = r_muser;
    assign tap_error          = r_err;

    for (genvar g = 0; g < CONV_UNITS; g++) begin : g_mac
        conv_mac_unit u_mac (
            .clk     (aclk),
            .rst     (areset),
            .i_en    (w_fire),
            .i_first (r_first),
            .i_pix   (axis.S_AXIS_tdata[g]),
            .i_w     (axis.W_AXIS_tdata),
            .o_sum   (w_sum[g])
        );
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_first <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_kw    <= '0;
            r_cin   <= '0;
        end else if (start) begin
            r_first <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_kw    <= kernel_w_1;
            r_cin   <= cin_1;
        end else if (w_fire) begin
            r_first <= axis.S_AXIS_tlast;
            r_cnt   <= axis.S_AXIS_tlast ? '0 : r_cnt + 1'b1;
            if (axis.S_AXIS_tlast != w_last_tap)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mvalid <= 1'b0;
            r_muser  <= '0;
            r_mdata  <= '{default: '0};
        end else if (w_last_fire) begin
            r_mvalid <= 1'b1;
            r_muser  <= axis.S_AXIS_tuser;
            r_mdata  <= w_sum;
        end else if (axis.M_AXIS_tready) begin
            r_mvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_conv_accumulator.sv
// tb_axis_conv_accumulator: table vectors, directed corner cases and randomized groups against a sum-of-products model.
module tb_axis_conv_accumulator;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic start = 1'b0;
    kw_t  kw1 = '0;
    cin_t cin1 = '0;
    logic tap_error;

    always #5 clk = ~clk;

    axis_conv_accumulator_if ifc ();

    axis_conv_accumulator dut (
        .aclk       (clk),
        .areset     (areset),
        .start      (start),
        .kernel_w_1 (kw1),
        .cin_1      (cin1),
        .axis       (ifc),
        .tap_error  (tap_error)
    );

    typedef struct { acc_t d[CONV_UNITS]; tuser_t tu; } exp_t;
    typedef struct { pix_t p; pix_t w; acc_t e; } vec_t;

    exp_t   expq[$];
    longint m_acc[CONV_UNITS];
    int     m_cnt, m_taps;
    bit     m_err;
    int     checks = 0;
    int     failures = 0;
    int     rdy_mode = 0;
    bit     fire_mvalid;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rdy_mode: 0 always ready, 1 stalled, 2 random backpressure
    always @(posedge clk) begin
        #1;
        ifc.M_AXIS_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!areset && ifc.M_AXIS_tvalid && ifc.M_AXIS_tready) begin
            if (expq.size() == 0)
                chk("unexpected_m_beat", 1, 0);
            else begin
                e = expq.pop_front();
                for (int u = 0; u < CONV_UNITS; u++)
                    chk($sformatf("m_data_u%0d", u), ifc.M_AXIS_tdata[u], e.d[u]);
                chk("m_tuser", ifc.M_AXIS_tuser, e.tu);
            end
        end
    end

    task automatic model_clear(input int taps);
        m_taps = taps;
        m_cnt  = 0;
        m_err  = 0;
        for (int u = 0; u < CONV_UNITS; u++) m_acc[u] = 0;
    endtask

    task automatic do_start(input int k, input int c);
        kw1   = kw_t'(k);
        cin1  = cin_t'(c);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        model_clear((k + 1) * (c + 1));
    endtask

    task automatic beat(input pix_t p[CONV_UNITS], input pix_t w, input bit last, input tuser_t tu, input int wgap);
        int   n = 0;
        bit   fired = 0;
        exp_t e;
        ifc.S_AXIS_tdata  = p;
        ifc.S_AXIS_tlast  = last;
        ifc.S_AXIS_tuser  = tu;
        ifc.W_AXIS_tdata  = w;
        ifc.S_AXIS_tvalid = 1'b1;
        for (int i = 0; i < wgap; i++) begin
            ifc.W_AXIS_tvalid = 1'b0;
            @(negedge clk);
            chk("unpaired_s_tready", ifc.S_AXIS_tready, 0);
            cyc(1);
        end
        ifc.W_AXIS_tvalid = 1'b1;
        while (!fired && n < 100) begin
            @(negedge clk);
            fired       = ifc.S_AXIS_tready;
            fire_mvalid = ifc.M_AXIS_tvalid;
            cyc(1);
            n++;
        end
        ifc.S_AXIS_tvalid = 1'b0;
        ifc.W_AXIS_tvalid = 1'b0;
        if (!fired) begin
            chk("beat_timeout", 0, 1);
            return;
        end
        for (int u = 0; u < CONV_UNITS; u++) m_acc[u] += longint'(p[u]) * longint'(w);
        m_cnt++;
        if (last) begin
            for (int u = 0; u < CONV_UNITS; u++) e.d[u] = acc_t'(m_acc[u]);
            e.tu = tu;
            expq.push_back(e);
            if (m_cnt != m_taps) m_err = 1;
            model_clear(m_taps);
            m_err = m_err | (m_cnt != 0);
        end else if (m_cnt == m_taps) begin
            m_err = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t pv[CONV_UNITS];
        vec_t tbl[6];
        bit   err_keep;
        ifc.S_AXIS_tdata  = '{default: '0};
        ifc.S_AXIS_tlast  = 1'b0;
        ifc.S_AXIS_tuser  = '0;
        ifc.W_AXIS_tdata  = '0;
        ifc.S_AXIS_tvalid = 1'b1;
        ifc.W_AXIS_tvalid = 1'b1;
        cyc(3);
        chk("rst_m_tvalid", ifc.M_AXIS_tvalid, 0);
        chk("rst_m_tdata", ifc.M_AXIS_tdata[0], 0);
        chk("rst_m_tuser", ifc.M_AXIS_tuser, 0);
        chk("rst_tap_error", tap_error, 0);
        chk("rst_s_tready", ifc.S_AXIS_tready, 0);
        chk("rst_w_tready", ifc.W_AXIS_tready, 0);
        ifc.S_AXIS_tvalid = 1'b0;
        ifc.W_AXIS_tvalid = 1'b0;
        areset = 1'b0;
        model_clear(1);
        cyc(1);

        tbl[0] = '{16'sh7fff, -16'sd1, -40'sd32767};
        tbl[1] = '{16'sh8000, 16'sh8000, 40'sd1073741824};
        tbl[2] = '{16'sh8000, 16'sh7fff, -40'sd1073709056};
        tbl[3] = '{16'sd5, 16'sd3, 40'sd15};
        tbl[4] = '{-16'sd2, 16'sd7, -40'sd14};
        tbl[5] = '{16'sd0, 16'sd1234, 40'sd0};
        do_start(0, 0);
        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = tbl[i].p;
            beat(pv, tbl[i].w, 1'b1, tuser_t'(i), 0);
            chk("vec_sum_u0", ifc.M_AXIS_tdata[0], tbl[i].e);
            chk("vec_sum_u7", ifc.M_AXIS_tdata[7], tbl[i].e);
            chk("vec_tuser", ifc.M_AXIS_tuser, i);
            chk("vec_tap_error", tap_error, 0);
        end

        do_start(2, 1);
        for (int k = 1; k <= 6; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u * 100 + k);
            beat(pv, 16'sd1, k == 6, 4'h5, 0);
        end
        chk("s1_valid_before", fire_mvalid, 0);
        chk("s1_valid_after", ifc.M_AXIS_tvalid, 1);
        for (int u = 0; u < CONV_UNITS; u++) chk("s1_sum", ifc.M_AXIS_tdata[u], 600 * u + 21);
        chk("s1_tap_error", tap_error, 0);
        cyc(1);
        chk("s1_valid_drop", ifc.M_AXIS_tvalid, 0);

        for (int k = 1; k <= 6; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = 16'sh7fff;
            beat(pv, -16'sd1, k == 6, 4'h0, 0);
        end
        for (int u = 0; u < CONV_UNITS; u++) chk("s2_sum", ifc.M_AXIS_tdata[u], -196602);

        for (int k = 1; k <= 6; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u * 100 + k);
            beat(pv, 16'sd1, k == 6, 4'h9, 1);
        end
        for (int u = 0; u < CONV_UNITS; u++) chk("s4_sum", ifc.M_AXIS_tdata[u], 600 * u + 21);

        do_start(0, 0);
        rdy_mode = 1;
        cyc(2);
        for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u + 1);
        beat(pv, 16'sd3, 1'b1, 4'h2, 0);
        for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(10 * u - 7);
        fork
            beat(pv, -16'sd2, 1'b1, 4'h3, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("s3_s_tready", ifc.S_AXIS_tready, 0);
                    chk("s3_w_tready", ifc.W_AXIS_tready, 0);
                    chk("s3_hold_valid", ifc.M_AXIS_tvalid, 1);
                    chk("s3_hold_data", ifc.M_AXIS_tdata[2], 9);
                end
                rdy_mode = 0;
            end
        join
        cyc(3);
        chk("s3_drained", expq.size(), 0);

        do_start(2, 1);
        for (int k = 1; k <= 4; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u - k);
            beat(pv, 16'sd2, k == 4, 4'h1, 0);
        end
        chk("s5_err_set", tap_error, 1);
        for (int k = 1; k <= 6; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u * k);
            beat(pv, 16'sd3, k == 6, 4'h4, 0);
        end
        chk("s5_err_sticky", tap_error, 1);
        do_start(2, 1);
        chk("s5_err_cleared", tap_error, 0);

        for (int k = 1; k <= 3; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(1000 + u);
            beat(pv, 16'sd5, 1'b0, 4'h0, 0);
        end
        areset = 1'b1;
        cyc(2);
        chk("s6_m_tvalid", ifc.M_AXIS_tvalid, 0);
        for (int u = 0; u < CONV_UNITS; u++) chk("s6_m_tdata", ifc.M_AXIS_tdata[u], 0);
        chk("s6_tap_error", tap_error, 0);
        areset = 1'b0;
        expq.delete();
        model_clear(1);
        cyc(1);
        do_start(2, 1);
        for (int k = 1; k <= 6; k++) begin
            for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'(u * 100 + k);
            beat(pv, 16'sd1, k == 6, 4'h7, 0);
        end
        for (int u = 0; u < CONV_UNITS; u++) chk("s6_sum", ifc.M_AXIS_tdata[u], 600 * u + 21);

        rdy_mode = 2;
        for (int g = 0; g < 30; g++) begin
            if (g % 6 == 0) do_start($urandom_range(0, 2), $urandom_range(0, 3));
            err_keep = m_err;
            for (int t = 0; t < m_taps; t++) begin
                for (int u = 0; u < CONV_UNITS; u++) pv[u] = pix_t'($urandom);
                beat(pv, pix_t'($urandom), t == m_taps - 1, tuser_t'($urandom), $urandom_range(0, 2));
            end
            chk("rand_tap_error", tap_error, err_keep | m_err);
        end
        rdy_mode = 0;
        cyc(10);
        chk("all_outputs_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
